// File: rtl/store_buffer_if.sv
// Bus bundle for the store buffer: store intake, memory drain port and load-forwarding lookup.
interface store_buffer_if #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [AWIDTH-1:0] st_addr;
  logic [WIDTH-1:0]  st_data;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_ack;
  logic [AWIDTH-1:0] ld_addr;
  logic              ld_hit;
  logic [WIDTH-1:0]  ld_data;
  logic [CW-1:0]     count;
  logic              empty;

  modport slave (
    input  st_valid, st_addr, st_data, mem_ack, ld_addr,
    output st_ready, mem_we, mem_addr, mem_wdata, ld_hit, ld_data, count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, mem_ack, ld_addr,
    input  st_ready, mem_we, mem_addr, mem_wdata, ld_hit, ld_data, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: FIFO of {addr, data} drained to memory by a two-state
// write FSM, with youngest-match forwarding to a pending load.
module store_buffer #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [AWIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0]  data_mem [DEPTH];

  logic push;
  logic pop;
  logic full;

  assign full = (count_q == CW'(DEPTH));
  // No full-bypass: a pop in the same cycle does not open a slot for a push.
  assign push = bus.st_valid && !full;
  assign pop  = (state_q == WRITE) && bus.mem_ack;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = WRITE;
      WRITE:   if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; occupancy is tracked only by pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= bus.st_addr;
      data_mem[tail_q] <= bus.st_data;
    end
  end

  logic             hit;
  logic [WIDTH-1:0] hit_data;
  logic [PW-1:0]    idx;

  // Scan oldest to youngest so the last match wins; an entry being pushed now is not yet counted.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_mem[idx] == bus.ld_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

  assign bus.st_ready  = !full;
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = (state_q == WRITE) ? addr_mem[head_q] : '0;
  assign bus.mem_wdata = (state_q == WRITE) ? data_mem[head_q] : '0;
  assign bus.ld_hit    = hit;
  assign bus.ld_data   = hit_data;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter AWIDTH, default 16: address width in bits.
REQ-003 Parameter DEPTH, default 4: number of entries; power of two, DEPTH >= 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 st_valid  input  1  datapath presents a store this cycle.
REQ-008 st_ready  output  1  buffer accepts a store this cycle.
REQ-009 st_addr  input  AWIDTH  store address.
REQ-010 st_data  input  WIDTH  store data.
REQ-011 mem_we  output  1  memory write request.
REQ-012 mem_addr  output  AWIDTH  memory write address.
REQ-013 mem_wdata  output  WIDTH  memory write data.
REQ-014 mem_ack  input  1  memory has completed the current write.
REQ-015 ld_addr  input  AWIDTH  address of a pending load, used for forwarding.
REQ-016 ld_hit  output  1  a buffered store matches ld_addr.
REQ-017 ld_data  output  WIDTH  forwarded store data.
REQ-018 count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-019 empty  output  1  high when count == 0.

Function
REQ-020 The buffer SHALL be an in-order FIFO of {addr, data} entries, with head and tail pointers wrapping modulo DEPTH.
REQ-021 st_ready SHALL equal (count != DEPTH), combinationally; a push occurs when st_valid && st_ready.
REQ-022 A push while full SHALL NOT occur, even if a pop happens in the same cycle; there is no full-bypass.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-024 The drain FSM SHALL have exactly two states: IDLE (mem_we=0) and WRITE (mem_we=1).
REQ-025 Transition IDLE->WRITE SHALL occur at the clock edge where count > 0; a store accepted at edge N raises mem_we at earliest after edge N+1, giving 1-cycle minimum latency.
REQ-026 In WRITE, mem_addr and mem_wdata SHALL present the head entry and hold it stable until mem_ack is sampled high.
REQ-027 On mem_ack in WRITE, the head entry SHALL pop; the FSM stays in WRITE if entries remain after the pop and the push, and otherwise returns to IDLE.
REQ-028 With mem_ack held high, back-to-back pops SHALL occur, one per cycle, with mem_we staying high.
REQ-029 mem_ack SHALL be ignored in IDLE.
REQ-030 mem_addr and mem_wdata SHALL be 0 while mem_we = 0.
REQ-031 ld_hit SHALL be combinational: 1 iff any occupied entry (including the head being written but not yet acked) has addr == ld_addr.
REQ-032 ld_data SHALL be the data of the youngest matching entry, and 0 when ld_hit = 0.
REQ-033 A store being pushed in the same cycle SHALL NOT be forwarded.
REQ-034 Storage array contents are not reset; validity is determined solely by pointers and count.

Reset
REQ-035 Asserting reset SHALL immediately force the FSM to IDLE, mem_we=0, mem_addr=0, mem_wdata=0, pointers=0, count=0, empty=1, st_ready=1, ld_hit=0, ld_data=0.
REQ-036 Reset during WRITE SHALL abandon the in-flight write and discard all entries; a mem_ack arriving after reset release SHALL be ignored.
REQ-037 After reset deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-038 Single store: after reset, push {0x0010, 0xBEEF} at edge N -> mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF after edge N+1; mem_ack high for one cycle -> count=0, empty=1, mem_we=0 after that edge.
REQ-039 Fill/backpressure: mem_ack=0, push 4 stores -> count=4, st_ready=0, and a 5th st_valid is not accepted; one mem_ack -> count=3, st_ready=1.
REQ-040 Forwarding: push {0x0020, 0x1111} then {0x0020, 0x2222}, mem_ack=0, ld_addr=0x0020 -> ld_hit=1, ld_data=0x2222; ld_addr=0x0030 -> ld_hit=0, ld_data=0; after both are acked, ld_addr=0x0020 -> ld_hit=0.
REQ-041 Streaming drain: 3 entries A, B, C buffered, mem_ack held at 1 -> writes of A, B, C on 3 consecutive cycles in order, then mem_we=0.
REQ-042 Wrap-around: 10 stores with interleaved random acks -> every address/data pair is written exactly once, in push order, and count never exceeds 4.
REQ-043 Reset mid-write: 2 entries buffered, mem_we=1, assert reset between edges -> mem_we=0 and count=0 before the next edge; a stale mem_ack after release produces no write.
